// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg: shared types and constants for the tile scheduler.
//   tile_sched_state_e : scheduler FSM states
//   BLK_DIM, WORD_W    : block edge length and packed-block word width
//   legal_size()       : matrix dimension check (even and at least BLK_DIM)
package tile_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        WAIT_A,
        REQ_B,
        WAIT_B,
        DRAIN
    } tile_sched_state_e;

    localparam int unsigned BLK_DIM = 2;
    localparam int unsigned WORD_W  = 32;

    function automatic logic legal_size(input logic [31:0] n);
        return (n[0] == 1'b0) && (n >= 32'(BLK_DIM));
    endfunction

endpackage

// File: rtl/tile_index_gen.sv
// tile_index_gen: i/j/k block-loop counters and A/B word-address formation.
// Loop order is i outer, j middle, k inner. Row offsets i*nblk and k*nblk are
// kept as running sums so no multiplier is needed; address math wraps silently.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   load                : latch nblk and bases, zero all indices
//   advance             : step to the next (i, j, k)
//   nblk                : block count per dimension (N/2)
//   base_a, base_b      : word addresses of block [0][0] of A and B
//   addr_a, addr_b      : addresses for the current (i, j, k)
//   last_k, last_all    : k is the final index / (i, j, k) is the final triple
module tile_index_gen #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [IDX_W-1:0]  nblk,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              last_k,
    output logic              last_all
);

    logic [IDX_W-1:0]  nblk_q;
    logic [IDX_W-1:0]  i_cnt, j_cnt, k_cnt;
    logic [ADDR_W-1:0] row_i, row_k;
    logic [ADDR_W-1:0] base_a_q, base_b_q;
    logic [ADDR_W-1:0] nblk_ext;
    logic              last_i, last_j;

    assign nblk_ext = ADDR_W'(nblk_q);
    assign last_i   = (i_cnt == nblk_q - IDX_W'(1));
    assign last_j   = (j_cnt == nblk_q - IDX_W'(1));
    assign last_k   = (k_cnt == nblk_q - IDX_W'(1));
    assign last_all = last_i && last_j && last_k;

    assign addr_a = base_a_q + row_i + ADDR_W'(k_cnt);
    assign addr_b = base_b_q + row_k + ADDR_W'(j_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nblk_q   <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            row_i    <= '0;
            row_k    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
        end else if (load) begin
            nblk_q   <= nblk;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            row_i    <= '0;
            row_k    <= '0;
            base_a_q <= base_a;
            base_b_q <= base_b;
        end else if (advance) begin
            if (!last_k) begin
                k_cnt <= k_cnt + IDX_W'(1);
                row_k <= row_k + nblk_ext;
            end else begin
                k_cnt <= '0;
                row_k <= '0;
                if (!last_j) begin
                    j_cnt <= j_cnt + IDX_W'(1);
                end else begin
                    j_cnt <= '0;
                    if (!last_i) begin
                        i_cnt <= i_cnt + IDX_W'(1);
                        row_i <= row_i + nblk_ext;
                    end else begin
                        i_cnt <= '0;
                        row_i <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: sequences an N x N int8 matmul through the 2x2 systolic core.
// Fetches one packed A block then one B block per (i, j, k) over a
// single-outstanding memory port, strobes them into the datapath and counts
// result blocks until all nblk^2 have returned.
// Optional feature macro: TILE_SCHED_PERF_EN adds perf_cycles / perf_stall.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   start, size, base_a/base_b : job request, dimension N and block bases
//   busy, done, err            : job status; done/err are one-cycle pulses
//   req_valid/ready/addr       : memory read request channel
//   rsp_valid/data             : memory read response (one packed block)
//   core_push_a/b, core_a/b    : block strobes and data to the datapath
//   core_last                  : qualifies core_push_b on the final k
//   core_valid                 : datapath result-block pulse
//   perf_cycles, perf_stall    : (TILE_SCHED_PERF_EN) busy and stall cycles
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SIZE_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SIZE_W-1:0] size,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [WORD_W-1:0] rsp_data,
    output logic              core_push_a,
    output logic              core_push_b,
    output logic [WORD_W-1:0] core_a,
    output logic [WORD_W-1:0] core_b,
    output logic              core_last,
    input  logic              core_valid
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned IDX_W = SIZE_W - 1;

    tile_sched_state_e state;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic              last_k, last_all;
    logic              last_k_q, last_all_q;
    logic [31:0]       result_cnt, result_next;
    logic [31:0]       blk_target;
    logic              start_ok;
    logic              advance;

    assign start_ok = (state == IDLE) && start && legal_size(32'(size));
    // Indices step once the B request of the current triple is accepted, so the
    // next A address is already formed when WAIT_B hands over to REQ_A.
    assign advance  = (state == REQ_B) && req_ready;

    always_comb begin
        result_next = result_cnt;
        if (core_valid && (state != IDLE)) begin
            result_next = result_cnt + 32'd1;
        end
    end

    tile_index_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_index_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (start_ok),
        .advance  (advance),
        .nblk     (size[SIZE_W-1:1]),
        .base_a   (base_a),
        .base_b   (base_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .last_k   (last_k),
        .last_all (last_all)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            core_push_a <= 1'b0;
            core_push_b <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            core_last   <= 1'b0;
            last_k_q    <= 1'b0;
            last_all_q  <= 1'b0;
            result_cnt  <= '0;
            blk_target  <= '0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            core_push_a <= 1'b0;
            core_push_b <= 1'b0;
            core_last   <= 1'b0;
            if (state != IDLE) begin
                result_cnt <= result_next;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            busy       <= 1'b1;
                            req_valid  <= 1'b1;
                            req_addr   <= base_a;
                            result_cnt <= '0;
                            blk_target <= '0;
                            state      <= REQ_A;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                REQ_A: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT_A;
                    end
                end
                WAIT_A: begin
                    if (rsp_valid) begin
                        core_a      <= rsp_data;
                        core_push_a <= 1'b1;
                        req_valid   <= 1'b1;
                        req_addr    <= addr_b;
                        state       <= REQ_B;
                    end
                end
                REQ_B: begin
                    if (req_ready) begin
                        req_valid  <= 1'b0;
                        last_k_q   <= last_k;
                        last_all_q <= last_all;
                        state      <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rsp_valid) begin
                        core_b      <= rsp_data;
                        core_push_b <= 1'b1;
                        core_last   <= last_k_q;
                        // Each completed k loop is one (i, j) result block owed
                        // by the datapath; the total reaches nblk^2 by DRAIN.
                        if (last_k_q) begin
                            blk_target <= blk_target + 32'd1;
                        end
                        if (last_all_q) begin
                            state <= DRAIN;
                        end else begin
                            req_valid <= 1'b1;
                            req_addr  <= addr_a;
                            state     <= REQ_A;
                        end
                    end
                end
                DRAIN: begin
                    if (result_next == blk_target) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic stalled;

    always_comb begin
        stalled = 1'b0;
        case (state)
            REQ_A, REQ_B:   stalled = !req_ready;
            WAIT_A, WAIT_B: stalled = !rsp_valid;
            default:        stalled = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (stalled) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: scoreboard bench for tile_scheduler.
// Stimulus pushes hand-listed request addresses, block data and core_last
// values into queues; a memory model answers requests; a monitor pops and
// compares whenever the DUT shows a handshake or a push strobe.
module tb_tile_scheduler;

    localparam int ADDR_W = 32;
    localparam int SIZE_W = 17;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] base_a, base_b;
    logic              busy, done, err;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              core_push_a, core_push_b;
    logic [31:0]       core_a, core_b;
    logic              core_last;
    logic              core_valid;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0]       perf_cycles, perf_stall;
`endif

    always #5 clk = ~clk;

    tile_scheduler #(
        .ADDR_W (ADDR_W),
        .SIZE_W (SIZE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .size        (size),
        .base_a      (base_a),
        .base_b      (base_b),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .core_push_a (core_push_a),
        .core_push_b (core_push_b),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_last   (core_last),
        .core_valid  (core_valid)
`ifdef TILE_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stall  (perf_stall)
`endif
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_last[$];

    int done_seen = 0;
    int hs_total  = 0;
    bit mem_random = 1'b0;

    // Expected request order for N = 4, base_a = 0x100, base_b = 0x200.
    logic [31:0] n4_addr [16] = '{
        32'h100, 32'h200, 32'h101, 32'h202, 32'h100, 32'h201, 32'h101, 32'h203,
        32'h102, 32'h200, 32'h103, 32'h202, 32'h102, 32'h201, 32'h103, 32'h203
    };

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_n4();
        for (int p = 0; p < 8; p++) begin
            exp_addr.push_back(n4_addr[2*p]);
            exp_addr.push_back(n4_addr[2*p+1]);
            exp_a.push_back(mem_word(n4_addr[2*p]));
            exp_b.push_back(mem_word(n4_addr[2*p+1]));
            exp_last.push_back((p % 2 == 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic push_n2(input logic [31:0] ba, input logic [31:0] bb);
        exp_addr.push_back(ba);
        exp_addr.push_back(bb);
        exp_a.push_back(mem_word(ba));
        exp_b.push_back(mem_word(bb));
        exp_last.push_back(32'd1);
    endtask

    task automatic do_start(input logic [SIZE_W-1:0] sz, input logic [31:0] ba,
                            input logic [31:0] bb);
        @(negedge clk);
        size   = sz;
        base_a = ba;
        base_b = bb;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        #3;
    endtask

    task automatic pulse_cv();
        @(negedge clk);
        core_valid = 1'b1;
        @(negedge clk);
        core_valid = 1'b0;
        #3;
    endtask

    task automatic wait_drained(input int budget);
        int  n = 0;
        logic ok;
        while ((exp_addr.size() != 0 || exp_b.size() != 0) && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        ok = (exp_addr.size() == 0) && (exp_b.size() == 0);
        check("queues_drained", 32'(ok), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({busy, done, err, req_valid, core_push_a, core_push_b,
                                   core_last}), 32'd0);
        check({tag, "_req_addr"}, req_addr, 32'd0);
        check({tag, "_core_a"}, core_a, 32'd0);
        check({tag, "_core_b"}, core_b, 32'd0);
    endtask

    // Memory model: one outstanding request, response after 0..5 idle cycles.
    initial begin : memory
        bit          pending;
        int          pend_cnt;
        logic [31:0] pend_addr;
        pending   = 1'b0;
        pend_cnt  = 0;
        pend_addr = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
            if (reset) begin
                pending = 1'b0;
            end else if (pending) begin
                if (pend_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_word(pend_addr);
                    pending   = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            req_ready = mem_random ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (!reset && req_valid && req_ready) begin
                if (pending || rsp_valid) begin
                    fails++;
                    tests++;
                    $display("FAIL overlap: got request at %h with one outstanding expected none",
                             req_addr);
                end
                pending   = 1'b1;
                pend_addr = req_addr;
                pend_cnt  = mem_random ? int'($urandom_range(0, 5)) : 0;
                hs_total++;
            end
        end
    end

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin : monitor
        bit          prev_stall;
        logic [31:0] prev_addr;
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("req_valid_held", 32'(req_valid), 32'd1);
                check("req_addr_stable", req_addr, prev_addr);
            end
            if (req_valid && req_ready) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_req", req_addr, 32'hFFFF_FFFF);
                end else begin
                    check("req_addr", req_addr, exp_addr.pop_front());
                end
            end
            prev_stall = req_valid && !req_ready;
            prev_addr  = req_addr;
            if (core_push_a) begin
                if (exp_a.size() == 0) check("unexpected_push_a", core_a, 32'hFFFF_FFFF);
                else check("core_a", core_a, exp_a.pop_front());
            end
            if (core_push_b) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_push_b", core_b, 32'hFFFF_FFFF);
                end else begin
                    check("core_b", core_b, exp_b.pop_front());
                    check("core_last", 32'(core_last), exp_last.pop_front());
                end
            end
            if (done) done_seen++;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int mark;
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        size       = '0;
        base_a     = '0;
        base_b     = '0;
        core_valid = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // N = 4, zero-wait memory; three results keep it draining, the fourth ends it.
        push_n4();
        do_start(17'd4, 32'h100, 32'h200);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_drained(400);
        repeat (3) pulse_cv();
        mark = done_seen;
        repeat (4) @(negedge clk);
        #3;
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_no_done", 32'(done_seen), 32'(mark));
        pulse_cv();
        check("done_after_4th", 32'(done), 32'd1);
        check("busy_falls_with_done", 32'(busy), 32'd0);
        @(negedge clk);
        #3;
        check("done_one_cycle", 32'(done), 32'd0);

        // Illegal sizes.
        mark = hs_total;
        do_start(17'd3, 32'h100, 32'h200);
        check("err_size3", 32'(err), 32'd1);
        check("busy_size3", 32'(busy), 32'd0);
        @(negedge clk);
        #3;
        check("err_pulse", 32'(err), 32'd0);
        do_start(17'd0, 32'h100, 32'h200);
        check("err_size0", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        #3;
        check("busy_after_err", 32'(busy), 32'd0);
        check("no_req_after_err", 32'(hs_total), 32'(mark));

        // Random memory latency, same job.
        mem_random = 1'b1;
        push_n4();
        do_start(17'd4, 32'h100, 32'h200);
        wait_drained(3000);
        repeat (4) pulse_cv();
        check("done_random", 32'(done), 32'd1);
        mem_random = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while the fifth request is on the port.
        mark = hs_total;
        push_n4();
        do_start(17'd4, 32'h100, 32'h200);
        n = 0;
        while (hs_total < mark + 5 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("reached_5th_req", 32'(hs_total - mark), 32'd5);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        #3;
        check_all_zero("held_reset");
        reset = 1'b0;
        exp_addr.delete();
        exp_a.delete();
        exp_b.delete();
        exp_last.delete();

        // N = 2 after reset: one A/B pair.
        mark = hs_total;
        push_n2(32'h40, 32'h80);
        do_start(17'd2, 32'h40, 32'h80);
        wait_drained(100);
        pulse_cv();
        check("done_n2", 32'(done), 32'd1);
        check("n2_req_count", 32'(hs_total - mark), 32'd2);

        // core_valid in IDLE and start while busy have no effect.
        mark = done_seen;
        pulse_cv();
        pulse_cv();
        check("idle_cv_no_done", 32'(done_seen), 32'(mark));
        check("idle_cv_no_busy", 32'(busy), 32'd0);
        mark = hs_total;
        push_n2(32'h300, 32'h400);
        do_start(17'd2, 32'h300, 32'h400);
        do_start(17'd4, 32'h999, 32'h777);
        wait_drained(100);
        check("busy_ignores_start", 32'(busy), 32'd1);
        pulse_cv();
        check("done_n2_b", 32'(done), 32'd1);
        check("n2_b_req_count", 32'(hs_total - mark), 32'd2);

        repeat (3) @(negedge clk);
        #3;
        check("scoreboard_empty", 32'(exp_addr.size() + exp_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
